// File: rtl/rxcommaalign_gpi_aggregator.sv
// Multi-channel comma-align GPI aggregator: synchronises per-channel rxcommaalignen into aclk,
// maps live levels onto the GPI bus and keeps sticky rise flags, saturating counters and an irq.
module rxcommaalign_gpi_aggregator #(
  parameter int NUM_CHANNELS = 4,
  parameter int GPI_WIDTH    = 16,
  parameter int BIT_OFFSET   = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_CHANNELS-1:0]           rxcommaalignen_in,
  input  logic [NUM_CHANNELS-1:0]           chan_mask,
  input  logic [NUM_CHANNELS-1:0]           sticky_clr,
  output logic [GPI_WIDTH-1:0]              gpi_out,
  output logic [NUM_CHANNELS-1:0]           sticky_out,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] cnt_out,
  output logic                              irq
);

  // Refuse to build rather than silently truncate the GPI field.
  if (BIT_OFFSET + NUM_CHANNELS > GPI_WIDTH) begin : g_bad_offset
    $error("rxcommaalign_gpi_aggregator: BIT_OFFSET+NUM_CHANNELS exceeds GPI_WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rxcommaalign_gpi_aggregator: SYNC_STAGES must be at least 2");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  (* ASYNC_REG = "TRUE" *) logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];

  logic [NUM_CHANNELS-1:0] sync_s;
  logic [NUM_CHANNELS-1:0] prev_q;
  logic [NUM_CHANNELS-1:0] rise;
  logic [GPI_WIDTH-1:0]    gpi_next;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_CHANNELS];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rxcommaalignen_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~prev_q;

  always_comb begin
    gpi_next = '0;
    gpi_next[BIT_OFFSET +: NUM_CHANNELS] = sync_s;
  end

  // A rise always lands in sticky, even when software clears in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_q     <= '0;
      gpi_out    <= '0;
      sticky_out <= '0;
      irq        <= 1'b0;
    end else begin
      prev_q     <= sync_s;
      gpi_out    <= gpi_next;
      sticky_out <= rise | (sticky_out & ~sticky_clr);
      irq        <= |(sticky_out & ~chan_mask);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) cnt_q[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (sticky_clr[ch]) begin
          cnt_q[ch] <= rise[ch] ? CNT_ONE : '0;
        end else if (rise[ch] && (cnt_q[ch] != CNT_MAX)) begin
          cnt_q[ch] <= cnt_q[ch] + CNT_ONE;
        end
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_cnt_out
    assign cnt_out[ch*CNT_WIDTH +: CNT_WIDTH] = cnt_q[ch];
  end

endmodule

// File: tb/tb_rxcommaalign_gpi_aggregator.sv
// Directed self-checking bench for rxcommaalign_gpi_aggregator at default parameters.
module tb_rxcommaalign_gpi_aggregator;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  rx_in;
  logic [3:0]  chan_mask;
  logic [3:0]  sticky_clr;
  logic [15:0] gpi_out;
  logic [3:0]  sticky_out;
  logic [31:0] cnt_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  rxcommaalign_gpi_aggregator dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .rxcommaalignen_in (rx_in),
    .chan_mask         (chan_mask),
    .sticky_clr        (sticky_clr),
    .gpi_out           (gpi_out),
    .sticky_out        (sticky_out),
    .cnt_out           (cnt_out),
    .irq               (irq)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    aresetn    = 1'b0;
    rx_in      = 4'b0000;
    chan_mask  = 4'b0000;
    sticky_clr = 4'b0000;
    tick(5);
    check_output("reset_gpi",    64'(gpi_out),    64'h0);
    check_output("reset_sticky", 64'(sticky_out), 64'h0);
    check_output("reset_cnt",    64'(cnt_out),    64'h0);
    check_output("reset_irq",    64'(irq),        64'h0);
    aresetn = 1'b1;
    tick(2);

    // Level mapping: three-cycle latency, other GPI bits stay zero.
    rx_in = 4'b0101;
    tick(2);
    check_output("gpi_not_yet", 64'(gpi_out), 64'h0000);
    tick(1);
    check_output("gpi_0101",     64'(gpi_out),    64'h0500);
    check_output("sticky_0101",  64'(sticky_out), 64'h5);
    check_output("cnt_0101",     64'(cnt_out),    64'h00010001);
    check_output("irq_lags",     64'(irq),        64'h0);
    tick(1);
    check_output("irq_set",      64'(irq),        64'h1);
    rx_in = 4'b1010;
    tick(3);
    check_output("gpi_1010",     64'(gpi_out),    64'h0A00);
    check_output("sticky_all",   64'(sticky_out), 64'hF);
    check_output("cnt_all_one",  64'(cnt_out),    64'h01010101);

    // Asynchronous reset away from any clock edge.
    #2;
    aresetn = 1'b0;
    rx_in   = 4'b0000;
    #1;
    check_output("async_gpi",    64'(gpi_out),    64'h0);
    check_output("async_sticky", 64'(sticky_out), 64'h0);
    check_output("async_cnt",    64'(cnt_out),    64'h0);
    check_output("async_irq",    64'(irq),        64'h0);
    aresetn = 1'b1;
    tick(3);

    // Channel 2 pulse, then write-1-to-clear.
    rx_in = 4'b0100;
    tick(3);
    rx_in = 4'b0000;
    check_output("pulse_sticky", 64'(sticky_out), 64'h4);
    check_output("pulse_cnt",    64'(cnt_out),    64'h00010000);
    tick(1);
    check_output("pulse_irq",    64'(irq),        64'h1);
    sticky_clr = 4'b0100;
    tick(1);
    sticky_clr = 4'b0000;
    check_output("clr_sticky",   64'(sticky_out), 64'h0);
    check_output("clr_cnt",      64'(cnt_out),    64'h0);
    check_output("clr_irq_lags", 64'(irq),        64'h1);
    tick(1);
    check_output("clr_irq",      64'(irq),        64'h0);

    // Collision: clear arrives in the same cycle as a new ch1 rise; counter loads 1, not 2.
    rx_in = 4'b0010;
    tick(3);
    rx_in = 4'b0000;
    check_output("pre_coll_cnt", 64'(cnt_out), 64'h00000100);
    tick(3);
    rx_in = 4'b0010;
    tick(2);
    sticky_clr = 4'b0010;
    tick(1);
    sticky_clr = 4'b0000;
    check_output("coll_sticky",  64'(sticky_out), 64'h2);
    check_output("coll_cnt",     64'(cnt_out),    64'h00000100);
    rx_in = 4'b0000;
    tick(3);

    // Saturation on channel 0.
    for (int i = 0; i < 254; i++) begin
      rx_in[0] = 1'b1;
      tick(2);
      rx_in[0] = 1'b0;
      tick(2);
    end
    check_output("cnt_254",      64'(cnt_out), 64'h000001FE);
    for (int i = 0; i < 46; i++) begin
      rx_in[0] = 1'b1;
      tick(2);
      rx_in[0] = 1'b0;
      tick(2);
    end
    tick(2);
    check_output("cnt_saturate", 64'(cnt_out), 64'h000001FF);

    // Masking with every sticky set; constant-high inputs count once.
    rx_in = 4'b1110;
    tick(4);
    check_output("mask_sticky",  64'(sticky_out), 64'hF);
    check_output("mask_cnt",     64'(cnt_out),    64'h010102FF);
    chan_mask = 4'b1111;
    tick(1);
    check_output("mask_irq_off", 64'(irq), 64'h0);
    chan_mask = 4'b0111;
    tick(1);
    check_output("mask_irq_on",  64'(irq), 64'h1);
    tick(20);
    check_output("held_cnt",     64'(cnt_out), 64'h010102FF);
    check_output("held_gpi",     64'(gpi_out), 64'h0E00);

    sticky_clr = 4'b1111;
    tick(1);
    sticky_clr = 4'b0000;
    check_output("final_sticky", 64'(sticky_out), 64'h0);
    check_output("final_cnt",    64'(cnt_out),    64'h0);
    tick(1);
    check_output("final_irq",    64'(irq),        64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rxcommaalign_gpi_aggregator.md
Name: rxcommaalign_gpi_aggregator

Overview:
- Multi-channel successor to the single-channel comma-align GPI bit mapper.
- Collects `rxcommaalignen` from NUM_CHANNELS GT channels, which arrive asynchronously from their RX clock domains, and synchronises them into `aclk`.
- Places the live levels into a contiguous GPI field. Adds per-channel sticky rise flags, saturating rise counters and a maskable interrupt, so software polling over GPIO cannot miss short alignment pulses.

Parameters:
- NUM_CHANNELS, 4, number of GT channels monitored (1..8).
- GPI_WIDTH, 16, width of the GPI bus driven to the GPIO block.
- BIT_OFFSET, 8, GPI bit index of channel 0. Channel n drives bit BIT_OFFSET+n.
- SYNC_STAGES, 2, flip-flop stages per input synchroniser (2..4).
- CNT_WIDTH, 8, width of each per-channel rise counter.

Ports:
- aclk  in  1  system clock; all logic is on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- rxcommaalignen_in  in  NUM_CHANNELS  per-channel comma-align enable, asynchronous to aclk.
- chan_mask  in  NUM_CHANNELS  1 = channel excluded from irq (sticky and counter still update).
- sticky_clr  in  NUM_CHANNELS  aclk-synchronous, one-cycle, write-1-to-clear for sticky and counter.
- gpi_out  out  GPI_WIDTH  synchronised live levels at BIT_OFFSET; all other bits 0.
- sticky_out  out  NUM_CHANNELS  per-channel "rise seen since last clear".
- cnt_out  out  NUM_CHANNELS*CNT_WIDTH  rise counters; channel n in bits [n*CNT_WIDTH +: CNT_WIDTH].
- irq  out  1  level interrupt: any unmasked sticky set.

Behaviour:
- Reset (aresetn low, asynchronous assert): every synchroniser stage, the prev register, gpi_out, sticky_out, cnt_out and irq go to 0 immediately. Deassertion is clocked normally.
- Elaboration check: if BIT_OFFSET+NUM_CHANNELS > GPI_WIDTH, or SYNC_STAGES < 2, elaboration fails with $error. There is no silent truncation.
- Synchroniser, per channel:
  - Chain of SYNC_STAGES registers with ASYNC_REG attributes; `s[n]` is the last stage.
  - `p[n]` registers `s[n]`.
  - Rise strobe `r[n] = s[n] & ~p[n]`. Falls generate nothing.
- gpi_out:
  - Registered: bit BIT_OFFSET+n <= s[n].
  - Latency from a stable input level to gpi_out is SYNC_STAGES+1 aclk cycles (±1 cycle for asynchronous sampling).
- sticky_out[n], per cycle:
  - r[n]=1 sets it to 1.
  - Else sticky_clr[n]=1 clears it to 0.
  - Else hold.
  - Simultaneous r and clr: set wins, so the new event is not lost.
  - A rise becomes visible in the same cycle as the gpi_out rise.
- cnt_out[n], per cycle:
  - sticky_clr[n] with r[n]: load 1.
  - sticky_clr[n] alone: load 0.
  - r[n] alone: increment, saturating at 2^CNT_WIDTH-1. It never wraps.
  - Otherwise hold.
- irq:
  - Registered: irq <= |(sticky_out & ~chan_mask), evaluated on current register values.
  - irq asserts one cycle after the sticky bit sets and deasserts one cycle after clear or mask.
  - Changing chan_mask alone takes effect in one cycle.
- Input pulses shorter than one aclk period may be missed. Guaranteed capture requires a high time of at least 2 aclk periods.
- Input held constant high: exactly one rise per 0→1 transition. No further counting.

Test Plan:
- Reset and idle: aresetn low 5 cycles, inputs 0 → gpi_out=16'h0000, sticky_out=0, cnt_out=0, irq=0. Assert aresetn mid-run with sticky=4'hF → all outputs 0 without an aclk edge.
- Level mapping (defaults): rxcommaalignen_in=4'b0101 held → gpi_out=16'h0500 after 3 cycles; then 4'b1010 → 16'h0A00. Bits 0..7 and 12..15 stay 0 throughout.
- Sticky/irq: pulse channel 2 high for 3 cycles, chan_mask=0 → sticky_out=4'b0100, cnt ch2=1, irq=1 one cycle after the sticky bit sets. sticky_clr=4'b0100 → sticky 0, count 0, irq 0 one cycle later.
- Set-wins collision: align the ch1 rise strobe with sticky_clr[1]=1 in the same cycle → sticky_out[1]=1, cnt ch1=1.
- Saturation: 300 rise events on ch0 with no clear → cnt ch0 = 8'hFF, remaining 255.
- Masking and elaboration check: chan_mask=4'b1111 with all stickies set → irq=0; clear mask bit 3 → irq=1 next cycle. Separately, BIT_OFFSET=14 with NUM_CHANNELS=4 → elaboration error.
